// File: rtl/tt_um_hoene_pkg.sv
// Shared definitions for the input scheduler: FSM state encodings and
// default timing parameters.
package tt_um_hoene_pkg;

    typedef enum logic [1:0] {
        SEL1  = 2'd0,  // in1 forwarded, in0 being qualified
        PEND0 = 2'd1,  // in0 qualified, waiting for a quiet gap on in1
        SEL0  = 2'd2,  // in0 forwarded, watching for in0 loss
        PEND1 = 2'd3   // in0 lost, waiting for a quiet gap on in0
    } sched_state_t;

    localparam int DEF_QUAL_EDGES    = 64;
    localparam int DEF_WINDOW_CYCLES = 4096;
    localparam int DEF_LOSS_CYCLES   = 8192;
    localparam int DEF_GAP_CYCLES    = 32;

endpackage

// File: rtl/tt_um_hoene_sync2.sv
// Two-flop synchronizer for one asynchronous serial input.
module tt_um_hoene_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic d_p0;

    // Metastability filter: pad -> d_p0 -> q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_p0 <= 1'b0;
            q    <= 1'b0;
        end else begin
            d_p0 <= d;
            q    <= d_p0;
        end
    end

endmodule

// File: rtl/tt_um_hoene_input_scheduler.sv
// Selects between two serial LED data inputs: in1 by default, in0 once it
// shows steady activity; switchovers happen only during a quiet gap on the
// currently forwarded input so no data frame is cut mid-way.
module tt_um_hoene_input_scheduler
    import tt_um_hoene_pkg::*;
#(
    parameter int QUAL_EDGES    = DEF_QUAL_EDGES,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int LOSS_CYCLES   = DEF_LOSS_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0,
    input  logic       in1,
    input  logic       testmode,
    output logic       out,
    output logic       in0selected,
    output logic       switched,
    output logic [1:0] state
);

    localparam int EW = $clog2(QUAL_EDGES + 1);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [EW-1:0] QUAL_MAX = EW'(QUAL_EDGES);
    localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW_CYCLES);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_CYCLES);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    logic s0, s1, s0_p2, s0_rise;
    logic sel, eff, gap_src, sw_nxt;
    sched_state_t state_q, state_nxt;
    logic [EW-1:0] edge_cnt, edge_nxt;
    logic [WW-1:0] win_cnt, win_nxt;
    logic [LW-1:0] loss_cnt, loss_nxt, loss_run;
    logic [GW-1:0] gap_cnt, gap_nxt, gap_run;

    tt_um_hoene_sync2 u_sync0 (.clk(clk), .rst(rst), .d(in0), .q(s0));
    tt_um_hoene_sync2 u_sync1 (.clk(clk), .rst(rst), .d(in1), .q(s1));

    assign s0_rise = s0 & ~s0_p2;
    assign sel     = (state_q == SEL0) || (state_q == PEND1);
    assign eff     = sel ^ testmode;
    assign state   = state_q;
    assign gap_src = (state_q == PEND0) ? s1 : s0;

    // Next-state logic and counter updates; counters not owned by the
    // current state default to zero, which also clears them on state entry.
    always_comb begin
        state_nxt = state_q;
        edge_nxt  = '0;
        win_nxt   = '0;
        loss_nxt  = '0;
        gap_nxt   = '0;
        sw_nxt    = 1'b0;
        loss_run  = s0_rise ? '0 : (loss_cnt == LOSS_MAX) ? loss_cnt : loss_cnt + 1'b1;
        gap_run   = gap_src ? '0 : (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;
        case (state_q)
            SEL1: begin
                // an expired window leaves both qualification counters at zero
                if (win_cnt != WIN_MAX) begin
                    edge_nxt = edge_cnt;
                    if (s0_rise && edge_cnt != QUAL_MAX) edge_nxt = edge_cnt + 1'b1;
                    if (edge_cnt != '0) win_nxt = win_cnt + 1'b1;
                    if (edge_nxt == QUAL_MAX) begin
                        state_nxt = PEND0;
                        edge_nxt  = '0;
                        win_nxt   = '0;
                    end
                end
            end
            PEND0: begin
                loss_nxt = loss_run;
                gap_nxt  = gap_run;
                // losing in0 outranks a simultaneous gap on in1
                if (loss_cnt == LOSS_MAX) begin
                    state_nxt = SEL1;
                    loss_nxt  = '0;
                    gap_nxt   = '0;
                end else if (gap_cnt == GAP_MAX) begin
                    state_nxt = SEL0;
                    sw_nxt    = 1'b1;
                    gap_nxt   = '0;
                end
            end
            SEL0: begin
                loss_nxt = loss_run;
                if (loss_cnt == LOSS_MAX) state_nxt = PEND1;
            end
            PEND1: begin
                // resumed in0 edges do not cancel; in0 must requalify from SEL1
                loss_nxt = loss_run;
                gap_nxt  = gap_run;
                if (gap_cnt == GAP_MAX) begin
                    state_nxt = SEL1;
                    sw_nxt    = 1'b1;
                    loss_nxt  = '0;
                    gap_nxt   = '0;
                end
            end
            default: state_nxt = SEL1;
        endcase
    end

    // State, counters, edge history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEL1;
            edge_cnt    <= '0;
            win_cnt     <= '0;
            loss_cnt    <= '0;
            gap_cnt     <= '0;
            s0_p2       <= 1'b0;
            out         <= 1'b0;
            in0selected <= 1'b0;
            switched    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            edge_cnt    <= edge_nxt;
            win_cnt     <= win_nxt;
            loss_cnt    <= loss_nxt;
            gap_cnt     <= gap_nxt;
            s0_p2       <= s0;
            out         <= eff ? s0 : s1;
            in0selected <= eff;
            switched    <= sw_nxt;
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_input_scheduler.sv
// Scenario bench for the input scheduler with shortened timing parameters.
module tb_tt_um_hoene_input_scheduler;

    logic clk = 1'b0;
    logic rst, in0, in1, testmode;
    logic out, in0selected, switched;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int sw_seen = 0;
    bit tog_en = 1'b0;
    bit h0[$];
    bit h1[$];
    int st_log[$];

    always #5 clk = ~clk;

    tt_um_hoene_input_scheduler #(
        .QUAL_EDGES(4), .WINDOW_CYCLES(64), .LOSS_CYCLES(32), .GAP_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .testmode(testmode),
        .out(out), .in0selected(in0selected), .switched(switched), .state(state)
    );

    // One clock: record pad values at the rising edge, observe at the falling edge.
    task automatic cyc();
        @(posedge clk);
        h0.push_back(in0);
        h1.push_back(in1);
        @(negedge clk);
        cyc_n++;
        if (switched === 1'b1) sw_seen++;
        if (st_log.size() == 0 || st_log[$] != int'(state)) st_log.push_back(int'(state));
        if (tog_en && (cyc_n % 4 == 0)) in1 = ~in1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in0 = 1'b0; in1 = 1'b0; testmode = 1'b0; tog_en = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        h0.delete(); h1.delete(); st_log.delete();
        sw_seen = 0;
    endtask

    task automatic pulse(input int hi, input int lo);
        in0 = 1'b1;
        repeat (hi) cyc();
        in0 = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic wait_state(input logic [1:0] want, input int limit);
        for (int i = 0; i < limit; i++) begin
            cyc();
            if (state === want) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in0 = 1'b0; in1 = 1'b1; testmode = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", out); end
        checks++; if (in0selected !== 1'b0) begin errors++; $display("FAIL reset_in0sel: got %b expected 0", in0selected); end
        checks++; if (switched !== 1'b0) begin errors++; $display("FAIL reset_switched: got %b expected 0", switched); end
        repeat (4) cyc();
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_hold_out: got %b expected 0", out); end
        rst = 1'b0;
        h0.delete(); h1.delete(); st_log.delete();
        sw_seen = 0;
    endtask

    task automatic test_sel1_follow();
        in0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in1 = 1'($urandom_range(0, 1));
            cyc();
            if (h1.size() >= 3) begin
                checks++;
                if (out !== h1[h1.size()-3]) begin
                    errors++; $display("FAIL sel1_out[%0d]: got %b expected %b", i, out, h1[h1.size()-3]);
                end
            end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL sel1_state: got %0d expected 0", state); end
        checks++; if (in0selected !== 1'b0) begin errors++; $display("FAIL sel1_in0sel: got %b expected 0", in0selected); end
    endtask

    task automatic test_testmode();
        do_reset();
        in1 = 1'b1;
        repeat (4) cyc();
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL tm_pre_out: got %b expected 1", out); end
        testmode = 1'b1;
        cyc();
        checks++; if (in0selected !== 1'b1) begin errors++; $display("FAIL tm_in0sel: got %b expected 1", in0selected); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL tm_state: got %0d expected 0", state); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL tm_out: got %b expected 0", out); end
        testmode = 1'b0;
        cyc();
        checks++; if (in0selected !== 1'b0) begin errors++; $display("FAIL tm_off_in0sel: got %b expected 0", in0selected); end
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL tm_off_out: got %b expected 1", out); end
    endtask

    task automatic test_qualify();
        int code;
        do_reset();
        in1 = 1'b1;
        for (int p = 0; p < 4; p++) pulse($urandom_range(1, 3), $urandom_range(1, 3));
        repeat (3) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL qual_pend0: got %0d expected 1", state); end
        in1 = 1'b0;
        wait_state(2'd2, 20);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL qual_sel0: got %0d expected 2", state); end
        checks++; if (switched !== 1'b1) begin errors++; $display("FAIL qual_switch_edge: got %b expected 1", switched); end
        repeat (2) cyc();
        checks++; if (in0selected !== 1'b1) begin errors++; $display("FAIL qual_in0sel: got %b expected 1", in0selected); end
        checks++; if (sw_seen != 1) begin errors++; $display("FAIL qual_single_switch: got %0d pulses expected 1", sw_seen); end
        code = 0;
        foreach (st_log[i]) code = code * 10 + st_log[i] + 1;
        checks++; if (code != 123) begin errors++; $display("FAIL qual_sequence: got code %0d expected 123", code); end
        // in0 now forwarded: random data with a guaranteed edge every 8 cycles
        for (int i = 0; i < 40; i++) begin
            in0 = (i % 8 == 0) ? 1'b0 : (i % 8 == 4) ? 1'b1 : 1'($urandom_range(0, 1));
            in1 = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (out !== h0[h0.size()-3]) begin
                errors++; $display("FAIL sel0_out[%0d]: got %b expected %b", i, out, h0[h0.size()-3]);
            end
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL sel0_state: got %0d expected 2", state); end
    endtask

    task automatic test_loss_pend1();
        in0 = 1'b0;
        repeat (2) cyc();
        in0 = 1'b1;
        sw_seen = 0;
        repeat (20) cyc();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL loss1_early: got %0d expected 2", state); end
        repeat (20) cyc();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL loss1_pend1: got %0d expected 3", state); end
        checks++; if (sw_seen != 0) begin errors++; $display("FAIL loss1_noswitch: got %0d pulses expected 0", sw_seen); end
        in0 = 1'b0;
        wait_state(2'd0, 20);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss1_sel1: got %0d expected 0", state); end
        checks++; if (switched !== 1'b1) begin errors++; $display("FAIL loss1_switch_edge: got %b expected 1", switched); end
        repeat (2) cyc();
        checks++; if (in0selected !== 1'b0) begin errors++; $display("FAIL loss1_in0sel: got %b expected 0", in0selected); end
        checks++; if (sw_seen != 1) begin errors++; $display("FAIL loss1_single_switch: got %0d pulses expected 1", sw_seen); end
    endtask

    task automatic test_window();
        do_reset();
        in1 = 1'b1;
        for (int p = 0; p < 3; p++) pulse(2, 2);
        repeat ($urandom_range(70, 90)) cyc();
        pulse(2, 2);
        repeat (4) cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL win_after_idle: got %0d expected 0", state); end
        // a count of 1 needs exactly 3 more edges to qualify
        for (int p = 0; p < 2; p++) pulse(2, 2);
        repeat (4) cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL win_three_edges: got %0d expected 0", state); end
        pulse(2, 2);
        repeat (4) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL win_four_edges: got %0d expected 1", state); end
    endtask

    task automatic test_loss_pend0();
        do_reset();
        in1 = 1'b1;
        tog_en = 1'b1;
        for (int p = 0; p < 4; p++) pulse(2, 2);
        repeat (3) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL loss0_pend0: got %0d expected 1", state); end
        in0 = 1'b0;
        sw_seen = 0;
        repeat (20) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL loss0_early: got %0d expected 1", state); end
        wait_state(2'd0, 30);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss0_sel1: got %0d expected 0", state); end
        checks++; if (sw_seen != 0) begin errors++; $display("FAIL loss0_noswitch: got %0d pulses expected 0", sw_seen); end
        tog_en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        in1 = 1'b1;
        for (int p = 0; p < 4; p++) pulse(2, 2);
        repeat (3) cyc();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL arst_pend0: got %0d expected 1", state); end
        in0 = 1'b1;
        testmode = 1'b1;
        repeat (4) cyc();
        checks++; if (in0selected !== 1'b1) begin errors++; $display("FAIL arst_pre_in0sel: got %b expected 1", in0selected); end
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL arst_pre_out: got %b expected 1", out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d expected 0", state); end
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL arst_out: got %b expected 0", out); end
        checks++; if (in0selected !== 1'b0) begin errors++; $display("FAIL arst_in0sel: got %b expected 0", in0selected); end
        checks++; if (switched !== 1'b0) begin errors++; $display("FAIL arst_switched: got %b expected 0", switched); end
        testmode = 1'b0;
        in0 = 1'b0;
        #1 rst = 1'b0;
        h0.delete(); h1.delete(); st_log.delete();
        for (int p = 0; p < 3; p++) pulse(2, 2);
        repeat (4) cyc();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_requal: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_sel1_follow();
        test_testmode();
        test_qualify();
        test_loss_pend1();
        test_window();
        test_loss_pend0();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_hoene_input_scheduler.md
TT_UM_HOENE_INPUT_SCHEDULER -- requirements
Module: tt_um_hoene_input_scheduler

Interface
REQ-001 SHALL have parameter QUAL_EDGES, default 64: in0 rising edges required to qualify in0.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 4096: qualification window length, in cycles.
REQ-003 SHALL have parameter LOSS_CYCLES, default 8192: in0 edge-free cycles that declare in0 lost.
REQ-004 SHALL have parameter GAP_CYCLES, default 32: consecutive low cycles on the selected input needed before a switchover.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-007 SHALL have port in0, input, 1: primary serial LED data, asynchronous to clk.
REQ-008 SHALL have port in1, input, 1: secondary serial LED data, asynchronous to clk.
REQ-009 SHALL have port testmode, input, 1: high inverts the effective selection.
REQ-010 SHALL have port out, output, 1: forwarded data, registered.
REQ-011 SHALL have port in0selected, output, 1: high when the effective source is in0.
REQ-012 SHALL have port switched, output, 1: one-cycle pulse when the internal selection changes.
REQ-013 SHALL have port state, output, 2: current FSM state encoding.

Function
REQ-014 SHALL pass in0 and in1 through two-flop synchronizers; s0/s1 denote the synchronized values.
REQ-015 SHALL implement FSM states SEL1=0 (in1 selected, qualifying in0), PEND0=1, SEL0=2, PEND1=3; internal sel=1 only in SEL0 and PEND1.
REQ-016 SHALL detect an in0 edge as s0 high while its previous registered value was low.
REQ-017 SHALL count edges in SEL1 with saturation at QUAL_EDGES; the window counter starts on the first edge; if the window counter reaches WINDOW_CYCLES before QUAL_EDGES, the edge count and window counter SHALL clear.
REQ-018 SHALL move SEL1->PEND0 in the cycle the edge count reaches QUAL_EDGES.
REQ-019 SHALL run the gap counter in PEND0 and PEND1 only: increment while the currently selected synchronized input (s1 in PEND0, s0 in PEND1) is low; clear on high or on state entry.
REQ-020 SHALL move PEND0->SEL0 on gap==GAP_CYCLES, pulsing switched in the same cycle sel changes.
REQ-021 SHALL run the loss counter in PEND0, SEL0 and PEND1: clear on each in0 edge; saturate at LOSS_CYCLES.
REQ-022 SHALL move SEL0->PEND1 when the loss counter reaches LOSS_CYCLES.
REQ-023 SHALL move PEND1->SEL1 on gap==GAP_CYCLES with a switched pulse; the qualification counters SHALL be cleared on entry to SEL1.
REQ-024 SHALL, when loss and gap occur together in PEND0, take loss: go to SEL1, no switched pulse, sel unchanged.
REQ-025 SHALL, when in0 edges resume in PEND1, remain in PEND1; in0 must requalify from SEL1.
REQ-026 SHALL set effective select eff = sel XOR testmode, combinationally from registered sel and live testmode.
REQ-027 SHALL register out <= eff ? s0 : s1 and in0selected <= eff; latency from pad to out is 3 cycles.
REQ-028 SHALL apply testmode changes on the next clock without gap qualification; testmode does not affect the FSM.
REQ-029 SHALL size all counters to $clog2(parameter+1) bits; no counter wraps.

Reset
REQ-030 SHALL, while rst is high, asynchronously force state=SEL1, sel=0, out=0, in0selected=0, switched=0, all counters and synchronizer flops to 0.
REQ-031 SHALL abort any in-progress pending switch or qualification on reset mid-operation; after release, normal operation starts from SEL1 with empty counters.

Structure
REQ-032 SHALL place the state encodings and default parameter values in shared package tt_um_hoene_pkg.
REQ-033 SHALL instantiate sub-module tt_um_hoene_sync2 (two-flop synchronizer, async active-high reset) once per data input.

Verification (override QUAL_EDGES=4, WINDOW_CYCLES=64, LOSS_CYCLES=32, GAP_CYCLES=8)
REQ-034 SHALL verify: 4 in0 pulses within 20 cycles, then in1 low for 8 cycles -> state 0->1->2, single switched pulse, in0selected=1 and out follows in0 with 3-cycle latency.
REQ-035 SHALL verify: 3 in0 pulses, 70 idle cycles, 1 pulse -> state stays 0, edge count =1.
REQ-036 SHALL verify: in SEL0, in0 held high for 40 cycles -> PEND1 at loss=32, remains PEND1 (s0 never low), no switch; then in0 low for 8 cycles -> SEL1, switched pulse, in0selected=0.
REQ-037 SHALL verify: in PEND0 with in1 toggling every 4 cycles, stop in0 -> after 32 edge-free cycles state=0, switched never asserted.
REQ-038 SHALL verify: testmode=1 in SEL1 -> in0selected=1 on the next clock, state unchanged; rst pulse in PEND0 -> all outputs 0 and state 0 immediately, without waiting for a clock edge.
